pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard controller for the 5-stage RV32I pipeline; replaces separate forward/hazard units.
//  Generates EX-stage operand forward selects and PC/IF-ID enables, ID/EX bubble and IF-ID/ID-EX flush controls.
//  Adds multi-cycle load-use stall (LOAD_LAT), data-memory wait freeze and taken-branch flush via a small FSM.
// PARAMETERS
//  REG_AW    5   register-index width (x0 always hard zero)
//  LOAD_LAT  1   load-use stall cycles inserted, 1..7
//  CNT_W     32  perf-counter width (used only when HZD_PERF_CNT_EN is defined)
// PORTS
//  clk            in   1       pipeline clock, rising edge
//  rst_n          in   1       async active-low reset
//  ifid_rs1/rs2   in   REG_AW  ID-stage source indices
//  ifid_rs1_used  in   1       ID instr reads rs1 (I/U/J gating)
//  ifid_rs2_used  in   1       ID instr reads rs2
//  idex_rs1/rs2   in   REG_AW  EX-stage source indices
//  idex_rs2_used  in   1       EX instr reads rs2 (0 for I-type: forwardB forced 00)
//  idex_mem_read  in   1       EX instr is a load
//  idex_rd        in   REG_AW  EX destination
//  exmem_reg_write in  1 ; exmem_rd in REG_AW ; exmem_mem_read in 1
//  memwb_reg_write in  1 ; memwb_rd in REG_AW
//  dmem_ready     in   1       data memory completes access this cycle
//  branch_taken   in   1       EX resolves taken branch/jump
//  forward_a/b    out  2       00 regfile, 10 EX/MEM, 01 MEM/WB
//  pc_write       out  1       PC load enable
//  ifid_write     out  1       IF/ID load enable
//  idex_bubble    out  1       insert NOP control word into ID/EX
//  exmem_write    out  1       EX/MEM+MEM/WB load enable (0 = freeze)
//  flush          out  1       clear IF/ID and ID/EX to NOP
//  stall_cycles/flush_count  out  CNT_W  perf counters (HZD_PERF_CNT_EN only)
// BEHAVIOUR
//  Forwarding (combinational): EX/MEM match beats MEM/WB; match needs reg_write=1, rd!=0, rd==rs;
//   forward_b=00 whenever idex_rs2_used=0.
//  load_use = idex_mem_read & idex_rd!=0 & ((ifid_rs1_used & idex_rd==ifid_rs1) | (ifid_rs2_used & idex_rd==ifid_rs2)).
//  mem_wait = exmem_mem_read & !dmem_ready.
//  FSM states RUN, LU_STALL, MEM_WAIT; 3-bit down-counter cnt. Priority: mem_wait > branch_taken > load_use.
//  RUN: mem_wait -> MEM_WAIT (freeze this cycle); else branch_taken -> flush=1, stay RUN;
//   else load_use -> stall this cycle; LOAD_LAT>1 -> LU_STALL, cnt=LOAD_LAT-1; else stay RUN.
//  LU_STALL: stall; cnt-1 each cycle; cnt==1 -> RUN. mem_wait here -> MEM_WAIT, cnt held, resumes LU_STALL after.
//  MEM_WAIT: freeze while mem_wait; on dmem_ready -> RUN (cnt==0) or LU_STALL (cnt!=0).
//  stall outputs: pc_write=0, ifid_write=0, idex_bubble=1, exmem_write=1, flush=0.
//  freeze outputs: pc_write=0, ifid_write=0, idex_bubble=0, exmem_write=0, flush=0 (branch_taken ignored).
//  normal outputs: pc_write=1, ifid_write=1, idex_bubble=0, exmem_write=1, flush=branch_taken.
//  Reset (rst_n=0, any time incl. mid-stall): state RUN, cnt=0, counters 0; outputs forced pc_write=0,
//   ifid_write=0, exmem_write=0, idex_bubble=1, flush=0, forward_a/b=00. First cycle after release = normal.
//  Latency: all controls combinational, same cycle as hazard inputs; FSM updates on clk rising edge.
// CONFIGURATION
//  HZD_PERF_CNT_EN defined: stall_cycles +1 per stall or freeze cycle, flush_count +1 per flush=1 cycle;
//   both saturate at all-ones. Undefined: ports absent, no counter flops.
// STRUCTURE
//  Shared package hzd_pkg: fwd_sel_t (FWD_REG=00, FWD_EXMEM=10, FWD_MEMWB=01), hzd_state_t enum, LOAD_LAT_MAX=7.
//  One sub-module fwd_sel (one operand's priority compare), instantiated twice for forward_a/b.
// TESTING
//  exmem rd=5 wr=1, memwb rd=5 wr=1, idex_rs1=5 -> forward_a=10; exmem rd=0 -> forward_a=01 (x0 never forwarded).
//  idex_rs2_used=0, exmem rd=idex_rs2=7 -> forward_b=00.
//  LOAD_LAT=3, load rd=4, ID rs2=4 used -> exactly 3 cycles pc_write=0/idex_bubble=1, then normal.
//  LOAD_LAT=1, load rd=4, ID rs1=4 but rs1_used=0 -> no stall.
//  exmem_mem_read=1, dmem_ready=0 for 4 cycles with branch_taken=1 -> 4 freeze cycles, flush=0; then normal.
//  rst_n low during cycle 2 of LU_STALL -> reset outputs, RUN after release; perf counters read 0.

Source files
------------

// File: rtl/hzd_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hzd_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_t;

    typedef enum logic [1:0] {
        StRun,
        StLuStall,
        StMemWait
    } hzd_state_t;

    localparam int unsigned LOAD_LAT_MAX = 7;

endpackage

// File: rtl/fwd_sel.sv
// One EX operand's forward select; EX/MEM result wins over MEM/WB, x0 is never forwarded.
module fwd_sel
    import hzd_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_REG;
        if (rs_used) begin
            if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding, load-use stall, data-memory freeze and branch flush control for the 5-stage pipeline.
// Optional perf counters (stall_cycles, flush_count) are built when HZD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import hzd_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ifid_rs1,
    input  logic [REG_AW-1:0] ifid_rs2,
    input  logic              ifid_rs1_used,
    input  logic              ifid_rs2_used,
    input  logic [REG_AW-1:0] idex_rs1,
    input  logic [REG_AW-1:0] idex_rs2,
    input  logic              idex_rs2_used,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_mem_read,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              dmem_ready,
    input  logic              branch_taken,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              exmem_write,
    output logic              flush
`ifdef HZD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    localparam logic [2:0] LuReload = 3'(LOAD_LAT - 1);

    fwd_sel_t   fwd_a, fwd_b;
    hzd_state_t state_q, state_d, eff_state;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use, mem_wait;
    logic       pc_w, ifid_w, bubble, exmem_w, flush_w;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs              (idex_rs1),
        .rs_used         (1'b1),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs              (idex_rs2),
        .rs_used         (idex_rs2_used),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (fwd_b)
    );

    assign load_use = idex_mem_read && (idex_rd != '0) &&
                      ((ifid_rs1_used && (idex_rd == ifid_rs1)) ||
                       (ifid_rs2_used && (idex_rd == ifid_rs2)));
    assign mem_wait = exmem_mem_read && !dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        bubble    = 1'b0;
        exmem_w   = 1'b1;
        flush_w   = 1'b0;
        // The cycle memory completes behaves as the state being resumed.
        eff_state = state_q;
        if (state_q == StMemWait && !mem_wait) begin
            eff_state = (cnt_q == 3'd0) ? StRun : StLuStall;
        end

        if (mem_wait) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            exmem_w = 1'b0;
            state_d = StMemWait;
        end else begin
            state_d = eff_state;
            unique case (eff_state)
                StRun: begin
                    if (branch_taken) begin
                        flush_w = 1'b1;
                    end else if (load_use) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StLuStall;
                            cnt_d   = LuReload;
                        end
                    end
                end
                StLuStall: begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    bubble  = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q == 3'd1) ? StRun : StLuStall;
                end
                default: state_d = StRun;
            endcase
        end
    end

    assign pc_write    = rst_n & pc_w;
    assign ifid_write  = rst_n & ifid_w;
    assign idex_bubble = !rst_n | bubble;
    assign exmem_write = rst_n & exmem_w;
    assign flush       = rst_n & flush_w;
    assign forward_a   = rst_n ? fwd_a : FWD_REG;
    assign forward_b   = rst_n ? fwd_b : FWD_REG;

`ifdef HZD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Stall and freeze cycles both hold the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_w && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (flush_w && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl using a LOAD_LAT=3 and a LOAD_LAT=1 instance.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic       ifid_rs1_used, ifid_rs2_used, idex_rs2_used, idex_mem_read;
    logic       exmem_reg_write, exmem_mem_read, memwb_reg_write, dmem_ready, branch_taken;

    logic [1:0] fa3, fb3, fa1, fb1;
    logic       pc3, ifid3, bub3, exw3, fl3;
    logic       pc1, ifid1, bub1, exw1, fl1;
`ifdef HZD_PERF_CNT_EN
    logic [31:0] sc3, fc3, sc1, fc1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic [8:0] exp3;
        logic [8:0] exp1;
    } sb_item_t;
    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rs2_used(idex_rs2_used),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_mem_read(exmem_mem_read),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .forward_a(fa3), .forward_b(fb3), .pc_write(pc3), .ifid_write(ifid3),
        .idex_bubble(bub3), .exmem_write(exw3), .flush(fl3)
`ifdef HZD_PERF_CNT_EN
        , .stall_cycles(sc3), .flush_count(fc3)
`endif
    );

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rs2_used(idex_rs2_used),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_mem_read(exmem_mem_read),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .forward_a(fa1), .forward_b(fb1), .pc_write(pc1), .ifid_write(ifid1),
        .idex_bubble(bub1), .exmem_write(exw1), .flush(fl1)
`ifdef HZD_PERF_CNT_EN
        , .stall_cycles(sc1), .flush_count(fc1)
`endif
    );

    // Expected word layout: {fwd_a, fwd_b, pc_write, ifid_write, idex_bubble, exmem_write, flush}
    localparam logic [4:0] NORM   = 5'b11010;
    localparam logic [4:0] FLUSH  = 5'b11011;
    localparam logic [4:0] STALL  = 5'b00110;
    localparam logic [4:0] FREEZE = 5'b00000;
    localparam logic [4:0] RST    = 5'b00100;

    function automatic logic [8:0] ex(input logic [1:0] a, input logic [1:0] b,
                                      input logic [4:0] ctl);
        return {a, b, ctl};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifid_rs1 = 0; ifid_rs2 = 0; ifid_rs1_used = 0; ifid_rs2_used = 0;
        idex_rs1 = 0; idex_rs2 = 0; idex_rs2_used = 0; idex_mem_read = 0; idex_rd = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_mem_read = 0;
        memwb_reg_write = 0; memwb_rd = 0; dmem_ready = 1; branch_taken = 0;
    endtask

    // Push expectation at drive time, pop and compare once outputs have settled.
    task automatic step(input string tag, input logic [8:0] e3, input logic [8:0] e1);
        sb_item_t it;
        logic [8:0] o3, o1;
        sb_q.push_back('{tag, e3, e1});
        #2;
        it = sb_q.pop_front();
        o3 = {fa3, fb3, pc3, ifid3, bub3, exw3, fl3};
        o1 = {fa1, fb1, pc1, ifid1, bub1, exw1, fl1};
        n_cmp++;
        assert (o3 === it.exp3) else begin
            n_bad++;
            $error("FAIL %s lat3: observed %b expected %b", it.tag, o3, it.exp3);
        end
        n_cmp++;
        assert (o1 === it.exp1) else begin
            n_bad++;
            $error("FAIL %s lat1: observed %b expected %b", it.tag, o1, it.exp1);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        exmem_reg_write = 1; exmem_rd = 5; idex_rs1 = 5;
        #3;
        step("reset_outputs", ex(2'b00, 2'b00, RST), ex(2'b00, 2'b00, RST));
        next_cycle();
        rst_n = 1;
        next_cycle();

        // Forwarding priority and x0 handling
        memwb_reg_write = 1; memwb_rd = 5;
        step("fwd_a_exmem", ex(2'b10, 2'b00, NORM), ex(2'b10, 2'b00, NORM));
        exmem_rd = 0;
        step("fwd_a_x0_memwb", ex(2'b01, 2'b00, NORM), ex(2'b01, 2'b00, NORM));
        exmem_reg_write = 0; exmem_rd = 5;
        step("fwd_a_nowr_memwb", ex(2'b01, 2'b00, NORM), ex(2'b01, 2'b00, NORM));
        idle_inputs();
        exmem_reg_write = 1; exmem_rd = 7; idex_rs2 = 7; idex_rs2_used = 1;
        step("fwd_b_exmem", ex(2'b00, 2'b10, NORM), ex(2'b00, 2'b10, NORM));
        idex_rs2_used = 0;
        step("fwd_b_unused", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));
        idle_inputs();
        memwb_reg_write = 1; memwb_rd = 7; idex_rs2 = 7; idex_rs2_used = 1;
        step("fwd_b_memwb", ex(2'b00, 2'b01, NORM), ex(2'b00, 2'b01, NORM));

        // Taken branch flush
        idle_inputs();
        branch_taken = 1;
        step("branch_flush", ex(2'b00, 2'b00, FLUSH), ex(2'b00, 2'b00, FLUSH));

        // Load-use on rs2: LOAD_LAT=3 stalls three cycles, LOAD_LAT=1 one cycle
        idle_inputs();
        next_cycle();
        idex_mem_read = 1; idex_rd = 4; ifid_rs2 = 4; ifid_rs2_used = 1;
        step("lu_c1", ex(2'b00, 2'b00, STALL), ex(2'b00, 2'b00, STALL));
        next_cycle();
        idex_mem_read = 0;
        step("lu_c2", ex(2'b00, 2'b00, STALL), ex(2'b00, 2'b00, NORM));
        next_cycle();
        step("lu_c3", ex(2'b00, 2'b00, STALL), ex(2'b00, 2'b00, NORM));
        next_cycle();
        step("lu_done", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));

        // Matching rs1 that the ID instruction does not read
        idle_inputs();
        idex_mem_read = 1; idex_rd = 4; ifid_rs1 = 4;
        step("lu_rs1_unused", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));
        idex_rd = 0; ifid_rs1_used = 1; ifid_rs1 = 0;
        step("lu_rd_x0", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));

        // Memory wait freezes and overrides a taken branch
        idle_inputs();
        next_cycle();
        exmem_mem_read = 1; dmem_ready = 0; branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            step("mem_freeze", ex(2'b00, 2'b00, FREEZE), ex(2'b00, 2'b00, FREEZE));
            next_cycle();
        end
        dmem_ready = 1; branch_taken = 0;
        step("mem_release", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));

        // Memory wait inside a load-use stall keeps the remaining count
        idle_inputs();
        next_cycle();
        idex_mem_read = 1; idex_rd = 9; ifid_rs1 = 9; ifid_rs1_used = 1;
        step("lu_mw_c1", ex(2'b00, 2'b00, STALL), ex(2'b00, 2'b00, STALL));
        next_cycle();
        idle_inputs();
        exmem_mem_read = 1; dmem_ready = 0;
        step("lu_mw_freeze", ex(2'b00, 2'b00, FREEZE), ex(2'b00, 2'b00, FREEZE));
        next_cycle();
        dmem_ready = 1;
        step("lu_mw_resume1", ex(2'b00, 2'b00, STALL), ex(2'b00, 2'b00, NORM));
        next_cycle();
        step("lu_mw_resume2", ex(2'b00, 2'b00, STALL), ex(2'b00, 2'b00, NORM));
        next_cycle();
        step("lu_mw_done", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));

        // Reset asserted in the second LU_STALL cycle
        idle_inputs();
        next_cycle();
        idex_mem_read = 1; idex_rd = 4; ifid_rs2 = 4; ifid_rs2_used = 1;
        step("rst_lu_c1", ex(2'b00, 2'b00, STALL), ex(2'b00, 2'b00, STALL));
        next_cycle();
        idle_inputs();
        next_cycle();
        rst_n = 0;
        step("rst_mid_stall", ex(2'b00, 2'b00, RST), ex(2'b00, 2'b00, RST));
`ifdef HZD_PERF_CNT_EN
        n_cmp++;
        assert ({sc3, fc3} === 64'd0) else begin
            n_bad++;
            $error("FAIL perf_cnt_reset: observed %0d/%0d expected 0/0", sc3, fc3);
        end
`endif
        next_cycle();
        rst_n = 1;
        step("rst_release", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));
        next_cycle();
        step("rst_after", ex(2'b00, 2'b00, NORM), ex(2'b00, 2'b00, NORM));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
